cfg_ls_stream_shadow: RTL and testbench

Double-buffered holding register for the load/store stream-select configuration words of the streaming memory interface. Software writes the shadow copy through a word-addressed request/grant port. On a kernel-start commit request the shadow copy is transferred atomically into the active copy, once the stream engine is idle. The active copy drives the flat `reg_cfg_l_stream_sel` / `reg_cfg_s_stream_sel` vectors that the stream-select decode stage slices into per-bank crossbar selects.

---
 rtl/mage_pkg.sv | 21 ++
 rtl/cfg_word_be_reg.sv | 21 ++
 rtl/cfg_ls_stream_shadow.sv | 157 +++++++++++++++
 tb/tb_cfg_ls_stream_shadow.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mage_pkg.sv
// Shared definitions for the MAGE streaming memory interface configuration path.
// Holds stream-config word counts and the load/store shadow-register FSM encoding.
package mage_pkg;

    localparam int N_CFG_REGS_LOAD_STREAM  = 2;
    localparam int N_CFG_REGS_STORE_STREAM = 2;

    localparam int LS_CFG_ADDR_W      = 6;
    localparam int LS_CFG_ACTIVE_BIT  = LS_CFG_ADDR_W - 1;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } cfg_shadow_state_e;

    // Position of the active-copy select bit for a given word-address width.
    function automatic int ls_cfg_active_bit(input int addr_w);
        return addr_w - 1;
    endfunction

endpackage

// File: rtl/cfg_word_be_reg.sv
// One 32-bit configuration word with per-byte write enables and synchronous reset.
module cfg_word_be_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) q[8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/cfg_ls_stream_shadow.sv
// Double-buffered load/store stream-select config: software writes a shadow copy, a commit
// moves it into the active copy once the stream engine is idle. Readback: MAGE_LS_CFG_READBACK_EN.
module cfg_ls_stream_shadow
    import mage_pkg::*;
#(
    parameter int N_L_REGS = N_CFG_REGS_LOAD_STREAM,
    parameter int N_S_REGS = N_CFG_REGS_STORE_STREAM,
    parameter int ADDR_W   = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cfg_req_i,
    input  logic                    cfg_we_i,
    input  logic [ADDR_W-1:0]       cfg_addr_i,
    input  logic [31:0]             cfg_wdata_i,
    input  logic [3:0]              cfg_be_i,
    output logic                    cfg_gnt_o,
    output logic                    cfg_rvalid_o,
    output logic [31:0]             cfg_rdata_o,
    output logic                    cfg_err_o,
    input  logic                    commit_req_i,
    input  logic                    busy_i,
    output logic                    pending_o,
    output logic                    commit_done_o,
    output logic [N_L_REGS*32-1:0]  reg_cfg_l_stream_sel_o,
    output logic [N_S_REGS*32-1:0]  reg_cfg_s_stream_sel_o
);

    localparam int N_REGS  = N_L_REGS + N_S_REGS;
    localparam int ACT_BIT = ls_cfg_active_bit(ADDR_W);

    // Handshake: an access transfers in any cycle where cfg_req_i and cfg_gnt_o are both high;
    // exactly one response (cfg_rvalid_o with rdata/err) follows in the next cycle, so
    // back-to-back grants give back-to-back responses and there is no response backpressure.

    cfg_shadow_state_e state_q, state_d;
    logic              commit_fire;

    logic                act_sel;
    logic [ADDR_W-2:0]   word_idx;
    int                  word_num;
    logic                mapped;
    logic                write_stall;
    logic                gnt;
    logic                wr_ok;
    logic                acc_err;
    logic [31:0]         rd_word;

    logic [N_REGS-1:0]   word_we;
    logic [31:0]         shadow_q [N_REGS];
    logic [31:0]         active_q [N_REGS];

    logic                rvalid_q;
    logic [31:0]         rdata_q;
    logic                err_q;
    logic                commit_done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        commit_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (commit_req_i) begin
                    if (busy_i) state_d     = PENDING;
                    else        commit_fire = 1'b1;
                end
            end
            PENDING: begin
                // Extra commit requests here are absorbed into the one already pending.
                if (!busy_i) begin
                    commit_fire = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign act_sel  = cfg_addr_i[ACT_BIT];
    assign word_idx = cfg_addr_i[ADDR_W-2:0];
    assign word_num = int'(word_idx);
    assign mapped   = (word_num < N_REGS);

    // Writes wait while a commit is requested or pending so the shadow stays stable for the copy.
    assign write_stall = cfg_we_i & (commit_req_i | (state_q == PENDING));
    assign gnt         = cfg_req_i & ~write_stall;
    assign cfg_gnt_o   = gnt;

    assign wr_ok   = gnt & cfg_we_i & ~act_sel & mapped;
    assign acc_err = (cfg_we_i & (act_sel | ~mapped)) | (~cfg_we_i & ~mapped);

    for (genvar gi = 0; gi < N_REGS; gi++) begin : g_shadow
        assign word_we[gi] = wr_ok && (word_num == gi);

        cfg_word_be_reg u_word (
            .clk   (clk_i),
            .rst   (rst_i),
            .we    (word_we[gi]),
            .be    (cfg_be_i),
            .wdata (cfg_wdata_i),
            .q     (shadow_q[gi])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_REGS; i++) active_q[i] <= '0;
        end else if (commit_fire) begin
            for (int i = 0; i < N_REGS; i++) active_q[i] <= shadow_q[i];
        end
    end

`ifdef MAGE_LS_CFG_READBACK_EN
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (word_num == i) rd_word = act_sel ? active_q[i] : shadow_q[i];
        end
    end
`else
    assign rd_word = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            commit_done_q <= 1'b0;
        end else begin
            rvalid_q      <= gnt;
            rdata_q       <= (gnt & ~cfg_we_i & ~acc_err) ? rd_word : 32'h0;
            err_q         <= gnt & acc_err;
            commit_done_q <= commit_fire;
        end
    end

    assign cfg_rvalid_o  = rvalid_q;
    assign cfg_rdata_o   = rdata_q;
    assign cfg_err_o     = err_q;
    assign commit_done_o = commit_done_q;
    assign pending_o     = (state_q == PENDING);

    for (genvar gl = 0; gl < N_L_REGS; gl++) begin : g_l_out
        assign reg_cfg_l_stream_sel_o[32*gl +: 32] = active_q[gl];
    end

    for (genvar gs = 0; gs < N_S_REGS; gs++) begin : g_s_out
        assign reg_cfg_s_stream_sel_o[32*gs +: 32] = active_q[N_L_REGS + gs];
    end

endmodule

// File: tb/tb_cfg_ls_stream_shadow.sv
// Directed bench for cfg_ls_stream_shadow (2 load words, 2 store words, 6-bit address).
// Expected read data follows MAGE_LS_CFG_READBACK_EN so either build can be checked.
module tb_cfg_ls_stream_shadow;

    logic        clk;
    logic        rst;
    logic        cfg_req;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [3:0]  cfg_be;
    logic        cfg_gnt;
    logic        cfg_rvalid;
    logic [31:0] cfg_rdata;
    logic        cfg_err;
    logic        commit_req;
    logic        busy;
    logic        pending;
    logic        commit_done;
    logic [63:0] l_sel;
    logic [63:0] s_sel;

    int total;
    int bad;

    cfg_ls_stream_shadow #(
        .N_L_REGS (2),
        .N_S_REGS (2),
        .ADDR_W   (6)
    ) dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .cfg_req_i              (cfg_req),
        .cfg_we_i               (cfg_we),
        .cfg_addr_i             (cfg_addr),
        .cfg_wdata_i            (cfg_wdata),
        .cfg_be_i               (cfg_be),
        .cfg_gnt_o              (cfg_gnt),
        .cfg_rvalid_o           (cfg_rvalid),
        .cfg_rdata_o            (cfg_rdata),
        .cfg_err_o              (cfg_err),
        .commit_req_i           (commit_req),
        .busy_i                 (busy),
        .pending_o              (pending),
        .commit_done_o          (commit_done),
        .reg_cfg_l_stream_sel_o (l_sel),
        .reg_cfg_s_stream_sel_o (s_sel)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected read data for shadow/active readback depends on build option.
    function automatic logic [31:0] rb(input logic [31:0] v);
`ifdef MAGE_LS_CFG_READBACK_EN
        return v;
`else
        return 32'h0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request for a cycle, check the grant, and leave the response visible.
    task automatic access(input logic we, input logic [5:0] addr, input logic [31:0] d,
                          input logic [3:0] be, input logic exp_gnt, input string tag);
        cfg_req   = 1'b1;
        cfg_we    = we;
        cfg_addr  = addr;
        cfg_wdata = d;
        cfg_be    = be;
        #1;
        chk({tag, " gnt"}, {63'd0, cfg_gnt}, {63'd0, exp_gnt});
        tick();
        cfg_req   = 1'b0;
        cfg_we    = 1'b0;
        cfg_wdata = '0;
        cfg_be    = '0;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [31:0] d, input logic e);
        chk({tag, " rvalid"}, {63'd0, cfg_rvalid}, {63'd0, v});
        chk({tag, " rdata"},  {32'd0, cfg_rdata},  {32'd0, d});
        chk({tag, " err"},    {63'd0, cfg_err},    {63'd0, e});
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        cfg_req    = 1'b0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_wdata  = '0;
        cfg_be     = '0;
        commit_req = 1'b0;
        busy       = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        chk_rsp("reset", 1'b0, 32'h0, 1'b0);
        chk("reset pending", {63'd0, pending}, 64'd0);
        chk("reset done",    {63'd0, commit_done}, 64'd0);
        chk("reset l_sel",   l_sel, 64'd0);
        chk("reset s_sel",   s_sel, 64'd0);
        chk("reset gnt",     {63'd0, cfg_gnt}, 64'd0);

        // Write then read-back, 1-cycle response
        access(1'b1, 6'd1, 32'hDEADBEEF, 4'hF, 1'b1, "wr1");
        chk_rsp("wr1 rsp", 1'b1, 32'h0, 1'b0);
        access(1'b0, 6'd1, 32'h0, 4'h0, 1'b1, "rd1");
        chk_rsp("rd1 rsp", 1'b1, rb(32'hDEADBEEF), 1'b0);
        access(1'b0, 6'd33, 32'h0, 4'h0, 1'b1, "rd33");
        chk_rsp("rd33 rsp", 1'b1, 32'h0, 1'b0);
        tick();
        chk_rsp("idle rsp", 1'b0, 32'h0, 1'b0);

        // Commit while idle
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        chk("commit idle l_sel hi", {32'd0, l_sel[63:32]}, {32'd0, 32'hDEADBEEF});
        chk("commit idle done", {63'd0, commit_done}, 64'd1);
        chk("commit idle pending", {63'd0, pending}, 64'd0);
        tick();
        chk("commit idle done once", {63'd0, commit_done}, 64'd0);
        access(1'b0, 6'd33, 32'h0, 4'h0, 1'b1, "rd33 post");
        chk_rsp("rd33 post rsp", 1'b1, rb(32'hDEADBEEF), 1'b0);

        // Commit while busy
        access(1'b1, 6'd0, 32'hA5A5A5A5, 4'hF, 1'b1, "wr0");
        busy       = 1'b1;
        commit_req = 1'b1;
        access(1'b1, 6'd0, 32'h0BAD0BAD, 4'hF, 1'b0, "wr commit stall");
        commit_req = 1'b0;
        chk_rsp("stall rsp", 1'b0, 32'h0, 1'b0);
        chk("busy pending", {63'd0, pending}, 64'd1);
        chk("busy done", {63'd0, commit_done}, 64'd0);
        chk("busy l_sel hold", l_sel, {32'hDEADBEEF, 32'h0});
        access(1'b1, 6'd1, 32'h0BAD0BAD, 4'hF, 1'b0, "wr pending stall");
        chk_rsp("pending stall rsp", 1'b0, 32'h0, 1'b0);
        access(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, "rd pending");
        chk_rsp("rd pending rsp", 1'b1, rb(32'hA5A5A5A5), 1'b0);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        tick();
        chk("still pending", {63'd0, pending}, 64'd1);
        chk("no early done", {63'd0, commit_done}, 64'd0);
        busy = 1'b0;
        tick();
        chk("busy commit done", {63'd0, commit_done}, 64'd1);
        chk("busy commit pending", {63'd0, pending}, 64'd0);
        chk("busy commit l_sel", l_sel, {32'hDEADBEEF, 32'hA5A5A5A5});
        tick();
        chk("busy commit done once", {63'd0, commit_done}, 64'd0);

        // Byte enables and invalid writes
        access(1'b1, 6'd2, 32'hFFFFFFFF, 4'hF, 1'b1, "wr2 ff");
        access(1'b1, 6'd2, 32'h12345678, 4'h3, 1'b1, "wr2 be");
        chk_rsp("wr2 be rsp", 1'b1, 32'h0, 1'b0);
        access(1'b0, 6'd2, 32'h0, 4'h0, 1'b1, "rd2");
        chk_rsp("rd2 rsp", 1'b1, rb(32'hFFFF5678), 1'b0);
        access(1'b1, 6'd34, 32'h00000001, 4'hF, 1'b1, "wr34");
        chk_rsp("wr34 rsp", 1'b1, 32'h0, 1'b1);
        chk("wr34 s_sel hold", s_sel, 64'd0);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        chk("commit s_sel", s_sel, {32'h0, 32'hFFFF5678});

        // Unmapped accesses
        access(1'b0, 6'd10, 32'h0, 4'h0, 1'b1, "rd10");
        chk_rsp("rd10 rsp", 1'b1, 32'h0, 1'b1);
        access(1'b1, 6'd10, 32'hCAFEF00D, 4'hF, 1'b1, "wr10");
        chk_rsp("wr10 rsp", 1'b1, 32'h0, 1'b1);

        // Reset during PENDING with a read in flight
        busy       = 1'b1;
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        chk("pre-reset pending", {63'd0, pending}, 64'd1);
        rst      = 1'b1;
        busy     = 1'b0;
        cfg_req  = 1'b1;
        cfg_addr = 6'd0;
        tick();
        rst     = 1'b0;
        cfg_req = 1'b0;
        chk("rst pending", {63'd0, pending}, 64'd0);
        chk("rst done", {63'd0, commit_done}, 64'd0);
        chk_rsp("rst rsp", 1'b0, 32'h0, 1'b0);
        chk("rst l_sel", l_sel, 64'd0);
        chk("rst s_sel", s_sel, 64'd0);
        tick();
        chk("rst no late done", {63'd0, commit_done}, 64'd0);

        // Write coincident with commit
        access(1'b1, 6'd3, 32'h11111111, 4'hF, 1'b1, "wr3 a");
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        chk("commit wr3 a", s_sel, {32'h11111111, 32'h0});
        commit_req = 1'b1;
        access(1'b1, 6'd3, 32'h22222222, 4'hF, 1'b0, "wr3 coincident");
        commit_req = 1'b0;
        chk("coincident done", {63'd0, commit_done}, 64'd1);
        access(1'b1, 6'd3, 32'h22222222, 4'hF, 1'b1, "wr3 b");
        chk("active holds pre-write", s_sel, {32'h11111111, 32'h0});
        access(1'b0, 6'd3, 32'h0, 4'h0, 1'b1, "rd3");
        chk_rsp("rd3 rsp", 1'b1, rb(32'h22222222), 1'b0);
        access(1'b0, 6'd35, 32'h0, 4'h0, 1'b1, "rd35");
        chk_rsp("rd35 rsp", 1'b1, rb(32'h11111111), 1'b0);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        chk("commit wr3 b", s_sel, {32'h22222222, 32'h0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
